// File: rtl/multdiv_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : multdiv_ctrl
// Purpose  : Execute-stage sequencer for the shared multi-cycle
//            multiplier/divider. Detects a mult/div in X, latches its
//            operands and destination, fires one start pulse, stalls the
//            front of the pipeline until the result returns (or a timeout
//            expires), then presents a single writeback beat. Exceptions and
//            timeouts are redirected to $r30 (rstatus).
// Ports    : clock, reset          - rising-edge clock, sync active-high reset
//            is_mult, is_div       - X-stage decode flags
//            operandA/B, rd_in     - X-stage operands and destination
//            md_result/exception/resultRDY - multdiv unit response
//            ctrl_MULT/ctrl_DIV    - multdiv start pulses
//            md_opA/md_opB         - latched operands to multdiv
//            stall, busy           - pipeline freeze / sequencer active
//            wb_valid/wb_rd/wb_data- writeback beat
//            timeout_err           - sticky timeout flag
// Revision : 1.0 - initial release
// ============================================================================
module multdiv_ctrl #(
    parameter int WIDTH       = 32,
    parameter int MAX_CYCLES  = 40,
    parameter int MULT_STATUS = 4,
    parameter int DIV_STATUS  = 5
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             is_mult,
    input  logic             is_div,
    input  logic [WIDTH-1:0] operandA,
    input  logic [WIDTH-1:0] operandB,
    input  logic [4:0]       rd_in,
    input  logic [WIDTH-1:0] md_result,
    input  logic             md_exception,
    input  logic             md_resultRDY,
    output logic             ctrl_MULT,
    output logic             ctrl_DIV,
    output logic [WIDTH-1:0] md_opA,
    output logic [WIDTH-1:0] md_opB,
    output logic             stall,
    output logic             busy,
    output logic             wb_valid,
    output logic [4:0]       wb_rd,
    output logic [WIDTH-1:0] wb_data,
    output logic             timeout_err
);

    localparam logic [1:0] c_IDLE  = 2'd0;
    localparam logic [1:0] c_START = 2'd1;
    localparam logic [1:0] c_WAIT  = 2'd2;
    localparam logic [1:0] c_WRITE = 2'd3;

    localparam int                 c_CNT_W    = $clog2(MAX_CYCLES + 1);
    localparam logic [c_CNT_W-1:0] c_LAST_CNT = c_CNT_W'(MAX_CYCLES - 1);
    localparam logic [4:0]         c_RSTATUS  = 5'd30;

    logic [1:0]         r_state;
    logic [c_CNT_W-1:0] r_count;
    logic [WIDTH-1:0]   r_op_a;
    logic [WIDTH-1:0]   r_op_b;
    logic [4:0]         r_rd;
    logic               r_op_is_mult;
    logic [WIDTH-1:0]   r_result;
    logic               r_exc;
    logic               r_timeout_err;

    logic w_start;
    logic w_in_write;
    logic [WIDTH-1:0] w_status;

    // Only IDLE looks at the decode flags; in WRITE they still describe the
    // instruction being retired, so sampling them there would re-issue it.
    assign w_start    = (r_state == c_IDLE) && (is_mult || is_div);
    assign w_in_write = (r_state == c_WRITE);
    assign w_status   = r_op_is_mult ? WIDTH'(MULT_STATUS) : WIDTH'(DIV_STATUS);

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state       <= c_IDLE;
            r_count       <= '0;
            r_op_a        <= '0;
            r_op_b        <= '0;
            r_rd          <= '0;
            r_op_is_mult  <= 1'b0;
            r_result      <= '0;
            r_exc         <= 1'b0;
            r_timeout_err <= 1'b0;
        end else begin
            case (r_state)
                c_IDLE: begin
                    if (w_start) begin
                        r_op_a       <= operandA;
                        r_op_b       <= operandB;
                        r_rd         <= rd_in;
                        // mult takes priority if decode flags both assert
                        r_op_is_mult <= is_mult;
                        r_state      <= c_START;
                    end
                end
                c_START: begin
                    // A ready pulse here belongs to no request of ours.
                    r_count <= '0;
                    r_state <= c_WAIT;
                end
                c_WAIT: begin
                    r_count <= r_count + 1'b1;
                    if (md_resultRDY) begin
                        r_result <= md_result;
                        r_exc    <= md_exception;
                        r_state  <= c_WRITE;
                    end else if (r_count == c_LAST_CNT) begin
                        r_exc         <= 1'b1;
                        r_timeout_err <= 1'b1;
                        r_state       <= c_WRITE;
                    end
                end
                default: begin
                    r_state <= c_IDLE;
                end
            endcase
        end
    end

    assign ctrl_MULT   = (r_state == c_START) &&  r_op_is_mult;
    assign ctrl_DIV    = (r_state == c_START) && !r_op_is_mult;
    assign md_opA      = r_op_a;
    assign md_opB      = r_op_b;
    // Stall is asserted combinationally on detection so the instruction
    // holds in X during the cycle it is latched.
    assign stall       = w_start || (r_state == c_START) || (r_state == c_WAIT);
    assign busy        = (r_state != c_IDLE);
    assign wb_valid    = w_in_write && (r_exc || (r_rd != 5'd0));
    assign wb_rd       = !w_in_write ? 5'd0 : (r_exc ? c_RSTATUS : r_rd);
    assign wb_data     = !w_in_write ? '0   : (r_exc ? w_status  : r_result);
    assign timeout_err = r_timeout_err;

endmodule
`default_nettype wire

// File: tb/tb_multdiv_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_multdiv_ctrl
// Purpose  : Self-checking bench for multdiv_ctrl: table of directed
//            operations plus hand-written timeout, back-to-back and
//            mid-operation reset sequences.
// Revision : 1.0 - initial release
// ============================================================================
module tb_multdiv_ctrl;

    localparam int WIDTH = 32;
    localparam int MAXC  = 40;

    logic             clock = 1'b0;
    logic             reset;
    logic             is_mult, is_div;
    logic [WIDTH-1:0] operandA, operandB;
    logic [4:0]       rd_in;
    logic [WIDTH-1:0] md_result;
    logic             md_exception, md_resultRDY;
    logic             ctrl_MULT, ctrl_DIV;
    logic [WIDTH-1:0] md_opA, md_opB;
    logic             stall, busy, wb_valid;
    logic [4:0]       wb_rd;
    logic [WIDTH-1:0] wb_data;
    logic             timeout_err;

    int errors = 0;
    int checks = 0;

    always #5 clock = ~clock;

    multdiv_ctrl #(
        .WIDTH(WIDTH), .MAX_CYCLES(MAXC), .MULT_STATUS(4), .DIV_STATUS(5)
    ) dut (
        .clock(clock), .reset(reset),
        .is_mult(is_mult), .is_div(is_div),
        .operandA(operandA), .operandB(operandB), .rd_in(rd_in),
        .md_result(md_result), .md_exception(md_exception),
        .md_resultRDY(md_resultRDY),
        .ctrl_MULT(ctrl_MULT), .ctrl_DIV(ctrl_DIV),
        .md_opA(md_opA), .md_opB(md_opB),
        .stall(stall), .busy(busy),
        .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data),
        .timeout_err(timeout_err)
    );

    typedef struct {
        logic        m;       // is_mult
        logic        d;       // is_div
        logic [31:0] a;
        logic [31:0] b;
        logic [4:0]  rd;
        int          rdy_at;  // cycle index of RDY (0 = detection), -1 never
        logic        spur;    // extra RDY pulse in the START cycle
        logic [31:0] res;
        logic        exc;
        logic        emult;   // expect ctrl_MULT (else ctrl_DIV)
        int          wc;      // expected WRITE cycle index = stall cycles
        logic        ev;
        logic [4:0]  erd;
        logic [31:0] edata;
    } vec_t;

    vec_t vecs[6];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Entered just after a rising edge; leaves just after the edge that
    // ends the WRITE cycle, with decode flags dropped.
    task automatic run_op(input vec_t v, input string tag);
        int  n_mult = 0, n_div = 0, n_stall = 0, wcyc = -1;
        bit  done = 0;
        is_mult  = v.m;  is_div   = v.d;
        operandA = v.a;  operandB = v.b;  rd_in = v.rd;
        for (int c = 0; c < 60 && !done; c++) begin
            md_resultRDY = (c == v.rdy_at) || (v.spur && c == 1);
            md_result    = (v.spur && c == 1) ? 32'h0000_0BAD : v.res;
            md_exception = (v.spur && c == 1) ? 1'b0 : v.exc;
            if (c == 2) operandA = 32'hDEAD_BEEF;
            @(negedge clock);
            if (c == 0) chk({tag, " idle_at_detect"}, {31'd0, busy}, 32'd0);
            if (ctrl_MULT) n_mult++;
            if (ctrl_DIV)  n_div++;
            if (stall)     n_stall++;
            if (busy && !stall) begin
                wcyc = c;
                done = 1;
                chk({tag, " wb_valid"}, {31'd0, wb_valid}, {31'd0, v.ev});
                if (v.ev) begin
                    chk({tag, " wb_rd"},   {27'd0, wb_rd}, {27'd0, v.erd});
                    chk({tag, " wb_data"}, wb_data, v.edata);
                end
                chk({tag, " md_opA"}, md_opA, v.a);
                chk({tag, " md_opB"}, md_opB, v.b);
            end
            @(posedge clock); #1;
        end
        is_mult = 0; is_div = 0; md_resultRDY = 0; md_exception = 0;
        chk({tag, " write_cycle"}, wcyc,    v.wc);
        chk({tag, " stall_cycles"}, n_stall, v.wc);
        chk({tag, " mult_pulses"}, n_mult,  v.emult ? 1 : 0);
        chk({tag, " div_pulses"},  n_div,   v.emult ? 0 : 1);
    endtask

    task automatic idle_check(input string tag);
        @(negedge clock);
        chk({tag, " post_idle"}, {29'd0, busy, stall, wb_valid}, 32'd0);
        @(posedge clock); #1;
    endtask

    initial begin
        vec_t tmo, op1, op2;
        int   bad_wb, bad_pulse, bad_busy;

        //            m  d  a            b   rd rdy spur res  exc emult wc ev erd  edata
        vecs[0] = '{1'b1,1'b0,32'd7,      32'd6, 5'd3, 6, 1'b0,32'd42,1'b0,1'b1,7,1'b1,5'd3, 32'd42};
        vecs[1] = '{1'b0,1'b1,32'd10,     32'd0, 5'd4, 4, 1'b0,32'd0, 1'b1,1'b0,5,1'b1,5'd30,32'd5};
        vecs[2] = '{1'b1,1'b0,32'h7FFFFFFF,32'd2,5'd7, 5, 1'b0,32'd0, 1'b1,1'b1,6,1'b1,5'd30,32'd4};
        vecs[3] = '{1'b1,1'b0,32'd3,      32'd5, 5'd0, 3, 1'b0,32'd15,1'b0,1'b1,4,1'b0,5'd0, 32'd0};
        vecs[4] = '{1'b1,1'b0,32'd4,      32'd5, 5'd2, 4, 1'b1,32'd20,1'b0,1'b1,5,1'b1,5'd2, 32'd20};
        vecs[5] = '{1'b1,1'b1,32'd2,      32'd3, 5'd5, 3, 1'b0,32'd6, 1'b0,1'b1,4,1'b1,5'd5, 32'd6};

        reset = 1; is_mult = 0; is_div = 0; operandA = 0; operandB = 0; rd_in = 0;
        md_result = 0; md_exception = 0; md_resultRDY = 0;
        repeat (2) @(posedge clock);
        #1 reset = 0;
        @(negedge clock);
        chk("reset ctrl/stall/busy/wb", {27'd0, ctrl_MULT, ctrl_DIV, stall, busy, wb_valid}, 32'd0);
        chk("reset wb_rd/timeout", {26'd0, wb_rd, timeout_err}, 32'd0);
        chk("reset wb_data", wb_data, 32'd0);
        chk("reset md_opA", md_opA, 32'd0);
        chk("reset md_opB", md_opB, 32'd0);
        @(posedge clock); #1;

        for (int i = 0; i < 6; i++) begin
            run_op(vecs[i], $sformatf("vec%0d", i));
            idle_check($sformatf("vec%0d", i));
        end
        chk("timeout_err clear", {31'd0, timeout_err}, 32'd0);

        // Timeout: RDY never comes; WRITE after MAXC WAIT cycles.
        tmo = '{1'b1,1'b0,32'd1,32'd1,5'd6,-1,1'b0,32'd0,1'b0,1'b1,42,1'b1,5'd30,32'd4};
        run_op(tmo, "timeout");
        chk("timeout_err set", {31'd0, timeout_err}, 32'd1);
        idle_check("timeout");

        // Back-to-back: div detected in the IDLE cycle straight after WRITE.
        op1 = '{1'b1,1'b0,32'd9, 32'd9,5'd10,4,1'b0,32'd81,1'b0,1'b1,5,1'b1,5'd10,32'd81};
        op2 = '{1'b0,1'b1,32'd50,32'd5,5'd11,3,1'b0,32'd10,1'b0,1'b0,4,1'b1,5'd11,32'd10};
        run_op(op1, "b2b_mult");
        run_op(op2, "b2b_div");
        idle_check("b2b");
        chk("timeout_err sticky", {31'd0, timeout_err}, 32'd1);

        // Reset three cycles after the start pulse, then a stale RDY.
        is_mult = 1; operandA = 8; operandB = 8; rd_in = 12;
        repeat (4) @(posedge clock);      // detect, START, WAIT, WAIT
        #1 reset = 1; is_mult = 0;
        @(posedge clock); #1 reset = 0;
        @(negedge clock);
        chk("rst_mid busy/stall/wb", {29'd0, busy, stall, wb_valid}, 32'd0);
        chk("rst_mid timeout_err", {31'd0, timeout_err}, 32'd0);
        @(posedge clock); #1;
        md_resultRDY = 1; md_result = 64;
        bad_wb = 0; bad_pulse = 0; bad_busy = 0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clock);
            if (wb_valid) bad_wb++;
            if (ctrl_MULT || ctrl_DIV) bad_pulse++;
            if (busy || stall) bad_busy++;
            @(posedge clock); #1;
            md_resultRDY = 0;
        end
        chk("rst_mid stale wb", bad_wb, 0);
        chk("rst_mid stale pulse", bad_pulse, 0);
        chk("rst_mid stale busy", bad_busy, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got running expected finished");
        $fatal(1);
    end

endmodule
`default_nettype wire

// File: doc/multdiv_ctrl.md
Name: multdiv_ctrl

Overview:
- Execute-stage sequencer for the shared multi-cycle multiplier/divider.
- Detects a mult/div instruction in X from the decoded is_mult/is_div flags.
- Latches the operands and destination register, then issues a single start pulse to the multdiv unit.
- Stalls F/D/X until the result is ready, then presents one writeback beat.
- On overflow or divide exception, the writeback goes to $r30 (rstatus) instead of rd.

Parameters:
- WIDTH, 32, operand/result width.
- MAX_CYCLES, 40, WAIT-state cycle limit before the operation is abandoned as timed out.
- MULT_STATUS, 4, rstatus value written on a mult exception.
- DIV_STATUS, 5, rstatus value written on a div exception.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high.
- is_mult  in  1  X-stage instruction is mul (from X decode).
- is_div  in  1  X-stage instruction is div (from X decode).
- operandA  in  WIDTH  X-stage rs value (post-bypass).
- operandB  in  WIDTH  X-stage rt value (post-bypass).
- rd_in  in  5  X-stage destination register.
- md_result  in  WIDTH  multdiv unit result.
- md_exception  in  1  multdiv overflow / divide-by-zero flag; valid with md_resultRDY.
- md_resultRDY  in  1  multdiv result valid, single-cycle pulse.
- ctrl_MULT  out  1  multdiv start-multiply pulse.
- ctrl_DIV  out  1  multdiv start-divide pulse.
- md_opA  out  WIDTH  latched operand A to multdiv.
- md_opB  out  WIDTH  latched operand B to multdiv.
- stall  out  1  freeze PC, F/D and D/X latches; insert bubble into X/M.
- busy  out  1  state != IDLE.
- wb_valid  out  1  writeback beat valid.
- wb_rd  out  5  writeback destination.
- wb_data  out  WIDTH  writeback data.
- timeout_err  out  1  sticky; set when a timeout occurs.

Behaviour:
- Reset (synchronous, active-high):
  - state=IDLE; counter=0; all latches 0.
  - All outputs 0; timeout_err cleared.
  - Reset mid-operation abandons the operation: no writeback, no further ctrl pulses.
- States: IDLE, START, WAIT, WRITE.
- IDLE:
  - start = is_mult | is_div.
  - stall = start, combinational, same cycle, so the instruction holds in X.
  - On start, latch operandA, operandB, rd_in and op_is_mult = is_mult; go to START.
  - If is_mult and is_div are both high, the operation is a mult.
- START:
  - ctrl_MULT = op_is_mult, or ctrl_DIV = !op_is_mult, high for exactly this cycle.
  - stall=1; counter cleared; go to WAIT.
  - md_resultRDY in START is ignored.
- WAIT:
  - stall=1; counter increments each cycle.
  - If md_resultRDY: capture md_result and md_exception; go to WRITE.
  - Else if counter == MAX_CYCLES-1: set timeout_err; go to WRITE with exception forced.
- WRITE, one cycle:
  - stall=0, so the pipeline advances the mult/div out of X at this edge.
  - is_mult/is_div are ignored in this cycle, because they still reflect the same instruction.
  - Always go to IDLE.
  - A following mult/div is detected in IDLE on the next cycle; back-to-back issue costs no extra bubble beyond that.
- Writeback in WRITE:
  - No exception: wb_valid = (rd != 0), wb_rd = rd, wb_data = result.
  - Exception or timeout: wb_valid=1, wb_rd=30, wb_data = MULT_STATUS or DIV_STATUS, zero-extended.
- md_opA/md_opB:
  - Driven from the latches, stable from START through WRITE.
  - Operand changes during the stall are ignored.
- Latency:
  - Detection at cycle T; pulse at T+1.
  - If RDY arrives at cycle T+1+k (k≥1), WRITE occurs at T+2+k and stall is high for cycles T..T+1+k.
- wb_valid, ctrl_MULT and ctrl_DIV are never high outside the states named above.
- busy = (state != IDLE).

Test Plan:
- Mult, 7×6: is_mult=1, A=7, B=6, rd=3; RDY with result=42 five cycles after the pulse. Required:
  - ctrl_MULT pulses exactly once.
  - stall high 7 cycles.
  - WRITE shows wb_valid=1, wb_rd=3, wb_data=42.
  - IDLE follows.
- Divide by zero: is_div, A=10, B=0, rd=4; RDY with md_exception=1. Required: ctrl_DIV pulse; wb_rd=30, wb_data=5. Repeat as mult with an exception: wb_data=4.
- Back-to-back: mult, then div in the next instruction. Required:
  - Div detected in the IDLE cycle after WRITE.
  - is_mult held during WRITE does not retrigger.
  - Two distinct writebacks, operands latched correctly despite operandA changing mid-stall.
- Timeout: is_mult, RDY never asserted. Required:
  - WRITE after MAX_CYCLES WAIT cycles.
  - wb_rd=30, wb_data=4.
  - timeout_err stays 1 until reset.
- rd=0 and spurious RDY: mult with rd=0 → no wb_valid, stall released normally. RDY pulsed in START → ignored; controller waits for the next RDY.
- Reset mid-WAIT: assert reset 3 cycles after the pulse. Required:
  - Next cycle state=IDLE, stall=0, no wb_valid.
  - A later RDY is ignored.
